// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, load/store port and shared bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the core-plus-bridge side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_valid;

  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_valid;

  logic              bus_req;
  logic              bus_wr;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  logic              stall;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_valid,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_valid,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output stall
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_valid,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_valid,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one SRAM-like bus.
// Define MEM_ARB_FAIR_EN for round-robin on contention; otherwise data always wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave mif
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_wr_q, bus_wr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              done;
  logic              grant_data;

  assign done = (state_q == WAIT) && mif.bus_data_ok;

`ifdef MEM_ARB_FAIR_EN
  // On contention hand the bus to whichever port did not own it last.
  assign grant_data = mif.data_req && (!mif.inst_req || !last_owner_q);
`else
  assign grant_data = mif.data_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (mif.inst_req || mif.data_req) begin
          state_d   = ADDR;
          bus_req_d = 1'b1;
          owner_d   = grant_data;
          if (grant_data) begin
            bus_wr_d    = mif.data_wr;
            bus_wstrb_d = mif.data_wstrb;
            bus_addr_d  = mif.data_addr;
            bus_wdata_d = mif.data_wdata;
          end else begin
            bus_wr_d    = 1'b0;
            bus_wstrb_d = 4'b0000;
            bus_addr_d  = mif.inst_addr;
            bus_wdata_d = '0;
          end
        end
      end
      ADDR: begin
        if (mif.bus_addr_ok) begin
          state_d   = WAIT;
          bus_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (mif.bus_data_ok) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          if (owner_q) data_rdata_d = mif.bus_rdata;
          else         inst_rdata_d = mif.bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= 4'b0000;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Completion is flagged in the same cycle the bus returns data, bypassing the hold register.
  assign mif.inst_valid = done && !owner_q;
  assign mif.data_valid = done && owner_q;
  assign mif.inst_rdata = mif.inst_valid ? mif.bus_rdata : inst_rdata_q;
  assign mif.data_rdata = mif.data_valid ? mif.bus_rdata : data_rdata_q;

  assign mif.bus_req   = bus_req_q;
  assign mif.bus_wr    = bus_wr_q;
  assign mif.bus_wstrb = bus_wstrb_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_wdata = bus_wdata_q;

  assign mif.stall = (mif.inst_req && !mif.inst_valid) || (mif.data_req && !mif.data_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: port requesters, a delay-programmable bus responder,
// and a negedge monitor that pops expected completions as valid pulses appear.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  req_t        inst_pend[$];
  req_t        data_pend[$];
  req_t        bus_exp[$];
  logic [31:0] inst_exp[$];
  exp_t        data_exp[$];
  int          inst_vcyc[$];
  int          inst_t0q[$];

  int inst_vld_cnt = 0;
  int data_vld_cnt = 0;
  int breq_cnt = 0;
  int aw_dly, dw_dly;
  bit spur_dok;
  int phase = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .mif (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic req_t mk(input logic wr, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d);
    req_t r;
    r.wr = wr; r.wstrb = s; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // Port requesters: drop a request the cycle after its valid, present the next one at once.
  initial begin : requester
    req_t r;
    exp_t e;
    int   inst_seen;
    int   data_seen;
    inst_seen = 0;
    data_seen = 0;
    bif.inst_req = 1'b0; bif.inst_addr = '0;
    bif.data_req = 1'b0; bif.data_wr = 1'b0; bif.data_wstrb = 4'b0;
    bif.data_addr = '0;  bif.data_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (inst_vld_cnt != inst_seen) begin inst_seen = inst_vld_cnt; bif.inst_req = 1'b0; end
        if (data_vld_cnt != data_seen) begin data_seen = data_vld_cnt; bif.data_req = 1'b0; end
        if (!bif.inst_req && inst_pend.size() > 0) begin
          r = inst_pend.pop_front();
          bif.inst_req = 1'b1; bif.inst_addr = r.addr;
          inst_exp.push_back(rd_model(r.addr));
          inst_t0q.push_back(cyc);
        end
        if (!bif.data_req && data_pend.size() > 0) begin
          r = data_pend.pop_front();
          bif.data_req = 1'b1; bif.data_wr = r.wr; bif.data_wstrb = r.wstrb;
          bif.data_addr = r.addr; bif.data_wdata = r.wdata;
          e.wr = r.wr; e.rdata = rd_model(r.addr);
          data_exp.push_back(e);
        end
      end
    end
  end

  // Bus responder: addr_ok after aw_dly cycles of bus_req, data_ok dw_dly cycles later.
  initial begin : responder
    req_t acc;
    int   rcnt;
    rcnt = 0;
    acc = '0;
    bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bif.bus_addr_ok = 1'b0;
      bif.bus_data_ok = 1'b0;
      if (rst) begin
        phase = 0; rcnt = 0;
      end else if (phase == 0) begin
        bif.bus_data_ok = spur_dok;
        if (spur_dok) bif.bus_rdata = 32'hDEAD_BEEF;
        if (bif.bus_req) begin
          if (bus_exp.size() == 0) check("bus_unexp_req", bif.bus_req, 0);
          else check("bus_fields", {bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata}, bus_exp[0]);
          if (rcnt >= aw_dly) begin
            bif.bus_addr_ok = 1'b1;
            acc = mk(bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata);
            if (bus_exp.size() > 0) void'(bus_exp.pop_front());
            phase = 1; rcnt = 0;
          end else rcnt++;
        end
      end else begin
        if (rcnt >= dw_dly) begin
          bif.bus_data_ok = 1'b1;
          bif.bus_rdata = acc.wr ? 32'h0BAD_5707 : rd_model(acc.addr);
          phase = 0; rcnt = 0;
        end else rcnt++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bif.bus_req) breq_cnt++;
      if (bif.inst_valid && bif.data_valid) check("dual_valid", bif.data_valid, 0);
      if (bif.inst_valid) begin
        inst_vld_cnt++;
        inst_vcyc.push_back(cyc);
        if (inst_exp.size() == 0) check("inst_unexp_valid", bif.inst_valid, 0);
        else check("inst_rdata", bif.inst_rdata, inst_exp.pop_front());
      end
      if (bif.data_valid) begin
        data_vld_cnt++;
        if (data_exp.size() == 0) check("data_unexp_valid", bif.data_valid, 0);
        else begin
          e = data_exp.pop_front();
          if (!e.wr) check("data_rdata", bif.data_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    do begin
      @(negedge clk);
      n++;
      idle = inst_pend.size() == 0 && data_pend.size() == 0 && !bif.inst_req && !bif.data_req &&
             inst_exp.size() == 0 && data_exp.size() == 0 && bus_exp.size() == 0 && phase == 0;
    end while (!idle && n < budget);
    check("idle_reached", idle, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, i0, d0, t0, n;
    aw_dly = 0; dw_dly = 0; spur_dok = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_bus_fields", {bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata}, 0);
    check("rst_valids", {bif.inst_valid, bif.data_valid}, 0);
    check("rst_rdata", {bif.inst_rdata, bif.data_rdata}, 0);
    check("rst_stall", bif.stall, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Single fetch, zero-wait bus
    @(negedge clk);
    inst_pend.push_back(mk(0, 4'b0, 32'hBFC0_0000, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'hBFC0_0000, 0));
    @(negedge clk);
    check("t1_stall_c0", bif.stall, 1);
    check("t1_breq_c0", bif.bus_req, 0);
    @(negedge clk);
    check("t1_breq_c1", bif.bus_req, 1);
    check("t1_baddr_c1", {bif.bus_wr, bif.bus_addr}, {1'b0, 32'hBFC0_0000});
    @(negedge clk);
    check("t1_ivalid_c2", bif.inst_valid, 1);
    check("t1_irdata_c2", bif.inst_rdata, 32'h3C08_0001);
    @(negedge clk);
    check("t1_stall_c3", bif.stall, 0);
    check("t1_ivalid_c3", bif.inst_valid, 0);
    check("t1_irdata_hold", bif.inst_rdata, 32'h3C08_0001);
    wait_idle(50);

    // Store with addr_ok delayed three cycles
    aw_dly = 3;
    b0 = breq_cnt; i0 = inst_vld_cnt; d0 = data_vld_cnt;
    data_pend.push_back(mk(1, 4'b0011, 32'h8000_0010, 32'h1234_5678));
    bus_exp.push_back(mk(1, 4'b0011, 32'h8000_0010, 32'h1234_5678));
    wait_idle(50);
    check("t2_breq_cycles", breq_cnt - b0, 4);
    check("t2_data_pulses", data_vld_cnt - d0, 1);
    check("t2_inst_pulses", inst_vld_cnt - i0, 0);
    aw_dly = 0;

    // Contention from a fresh reset
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("t3_rst_irdata", bif.inst_rdata, 0);
    check("t3_rst_state", bif.bus_req, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    dw_dly = 1;
    data_pend.push_back(mk(0, 4'b0, 32'h0000_0100, 0));
    data_pend.push_back(mk(0, 4'b0, 32'h0000_0104, 0));
    data_pend.push_back(mk(0, 4'b0, 32'h0000_0108, 0));
    inst_pend.push_back(mk(0, 4'b0, 32'h0000_0200, 0));
`ifdef MEM_ARB_FAIR_EN
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0100, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0200, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0104, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0108, 0));
`else
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0100, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0104, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0108, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0200, 0));
`endif
    wait_idle(200);
    check("t3_stall_end", bif.stall, 0);
    dw_dly = 0;

    // Back-to-back fetches, zero-wait bus
    i0 = inst_vcyc.size(); t0 = inst_t0q.size();
    inst_pend.push_back(mk(0, 4'b0, 32'h0000_0000, 0));
    inst_pend.push_back(mk(0, 4'b0, 32'h0000_0004, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0000, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0004, 0));
    wait_idle(50);
    check("t4_first_lat", inst_vcyc[i0] - inst_t0q[t0], 2);
    check("t4_second_lat", inst_vcyc[i0 + 1] - inst_t0q[t0], 5);

    // Reset while waiting for data
    dw_dly = 6;
    inst_pend.push_back(mk(0, 4'b0, 32'h0000_0040, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0040, 0));
    n = 0;
    while (phase != 1 && n < 20) begin @(negedge clk); n++; end
    check("t5_reach_accept", phase, 1);
    @(negedge clk);
    check("t5_wait_breq", bif.bus_req, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_exp.delete();
    inst_exp.delete();
    @(negedge clk);
    check("t5_rst_breq", bif.bus_req, 0);
    check("t5_rst_ivalid", bif.inst_valid, 0);
    check("t5_rst_baddr", bif.bus_addr, 0);
    check("t5_rst_stall", bif.stall, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    dw_dly = 0;
    inst_exp.push_back(rd_model(32'h0000_0040));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0040, 0));
    @(negedge clk);
    check("t5_restart_c0", bif.bus_req, 0);
    @(negedge clk);
    check("t5_restart_c1", bif.bus_req, 1);
    wait_idle(50);

    // Spurious data_ok in IDLE, then in ADDR
    i0 = inst_vld_cnt;
    spur_dok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_breq", bif.bus_req, 0);
    end
    check("t6_irdata_hold", bif.inst_rdata, rd_model(32'h0000_0040));
    aw_dly = 3;
    b0 = breq_cnt;
    inst_pend.push_back(mk(0, 4'b0, 32'h0000_0080, 0));
    bus_exp.push_back(mk(0, 4'b0, 32'h0000_0080, 0));
    wait_idle(50);
    spur_dok = 1'b0;
    aw_dly = 0;
    check("t6_breq_cycles", breq_cnt - b0, 4);
    check("t6_inst_pulses", inst_vld_cnt - i0, 1);

    check("final_queues", inst_exp.size() + data_exp.size() + bus_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
